// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// memory-access sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a writing stage targets a real register that a reader sources.
  function automatic logic reg_match(input logic [4:0] dst, input logic wr_en,
                                     input logic [4:0] src);
    return wr_en && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/mem_access_seq.sv
// MEM-stage data-memory sequencer: RUN / MEM_WAIT / ERR with a bounded wait
// counter. Drives the request and the pipeline-freeze indication.
module mem_access_seq
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_freeze,
  output logic flush_w,
  output logic mem_err
);

  localparam logic [8:0] TIMEOUT_W = 9'(MEM_TIMEOUT);

  mem_state_e state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_req    = 1'b0;
    mem_freeze = 1'b0;
    flush_w    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        mem_req = mem_read | mem_write;
        if (mem_req && !mem_ack) begin
          mem_freeze = 1'b1;
          flush_w    = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          mem_freeze = 1'b1;
          flush_w    = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
          // The counter never wraps: ERR is taken no later than 255.
          if (9'(wait_cnt_q) + 9'd1 >= TIMEOUT_W) state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        mem_freeze = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_err = (state_q == ST_ERR);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush/forward controller for the 5-stage pipeline.
// Optional operand forwarding enabled by defining HAZARD_FORWARD_EN.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReadE,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic             BranchTakenE,
  input  logic             MemAckM,
  output logic             MemReqM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles
);

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic mem_req, mem_freeze, flush_w, mem_err;

  mem_access_seq #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_seq (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .mem_read  (MemReadM),
    .mem_write (MemWriteM),
    .mem_ack   (MemAckM),
    .mem_req   (mem_req),
    .mem_freeze(mem_freeze),
    .flush_w   (flush_w),
    .mem_err   (mem_err)
  );

  logic       dep_e, dep_m, load_use, stall_hazard;
  logic [1:0] fwd_a, fwd_b;

  // Without forwarding, any in-flight producer in EX or MEM must stall ID.
  always_comb begin
    dep_e        = reg_match(WriteRegE, RegWriteE, RsD) | reg_match(WriteRegE, RegWriteE, RtD);
    dep_m        = reg_match(WriteRegM, RegWriteM, RsD) | reg_match(WriteRegM, RegWriteM, RtD);
    load_use     = MemReadE & dep_e;
    stall_hazard = FWD_EN ? load_use : (dep_e | dep_m);
    fwd_a = reg_match(WriteRegM, RegWriteM, RsE) ? FWD_MEM :
            reg_match(WriteRegW, RegWriteW, RsE) ? FWD_WB  : FWD_REG;
    fwd_b = reg_match(WriteRegM, RegWriteM, RtE) ? FWD_MEM :
            reg_match(WriteRegW, RegWriteW, RtE) ? FWD_WB  : FWD_REG;
    if (!FWD_EN) begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
    end
  end

  // Priority: memory freeze, then taken branch, then data hazard.
  always_comb begin
    MemReqM   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = FWD_REG;
    ForwardBE = FWD_REG;
    if (Rst_n) begin
      MemReqM   = mem_req;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = flush_w;
      end else if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (stall_hazard) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (StallF && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign StallCycles = stall_cycles_q;
  assign MemErr      = mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle behavioural model
// plus directed vectors with literal expectations.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic Clk = 1'b0, Rst_n;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, MemWriteM;
  logic BranchTakenE, MemAckM;
  logic MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .BranchTakenE(BranchTakenE), .MemAckM(MemAckM), .MemReqM(MemReqM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCycles(StallCycles)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] dst, input logic en, input logic [4:0] src);
    return en && dst != 5'd0 && dst == src;
  endfunction

  // Model: count how many cycles the current access has gone unacknowledged;
  // once that reaches TIMEOUT the controller is dead until reset.
  initial begin
    int  pend = 0, pend_n;
    bit  err = 0, err_n;
    int  scnt = 0, scnt_n;
    bit  req, hold, br, hz, sf, fe, fd, fw;
    logic [1:0] fa, fb;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        check("rst_outputs", {MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE,
                              FlushW, ForwardAE, ForwardBE, MemErr}, 32'd0);
        check("rst_count", 32'(StallCycles), 32'd0);
        pend_n = 0; err_n = 0; scnt_n = 0;
      end else begin
        req  = !err && (MemReadM || MemWriteM || pend > 0);
        hold = err || (req && !MemAckM);
        fw   = !err && req && !MemAckM;
        br   = !hold && BranchTakenE;
        hz   = FWD ? (MemReadE && (hit(WriteRegE, RegWriteE, RsD) || hit(WriteRegE, RegWriteE, RtD)))
                   : (hit(WriteRegE, RegWriteE, RsD) || hit(WriteRegE, RegWriteE, RtD) ||
                      hit(WriteRegM, RegWriteM, RsD) || hit(WriteRegM, RegWriteM, RtD));
        sf   = hold || (!BranchTakenE && hz);
        fd   = br;
        fe   = !hold && (BranchTakenE || hz);
        fa   = !FWD ? 2'b00 : hit(WriteRegM, RegWriteM, RsE) ? 2'b10 :
                              hit(WriteRegW, RegWriteW, RsE) ? 2'b01 : 2'b00;
        fb   = !FWD ? 2'b00 : hit(WriteRegM, RegWriteM, RtE) ? 2'b10 :
                              hit(WriteRegW, RegWriteW, RtE) ? 2'b01 : 2'b00;
        check("outputs", {MemReqM, StallF, StallD, StallE, StallM, FlushD, FlushE,
                          FlushW, ForwardAE, ForwardBE, MemErr},
              {req, sf, sf, hold, hold, fd, fe, fw, fa, fb, err});
        check("stall_count", 32'(StallCycles), 32'(scnt));
        err_n  = err;
        pend_n = 0;
        if (!err && req && !MemAckM) begin
          pend_n = pend + 1;
          if (pend_n >= TIMEOUT) begin err_n = 1; pend_n = 0; end
        end
        scnt_n = (sf && scnt < (1 << CNT_W) - 1) ? scnt + 1 : scnt;
      end
      @(posedge Clk);
      if (!Rst_n) begin pend = 0; err = 0; scnt = 0; end
      else        begin pend = pend_n; err = err_n; scnt = scnt_n; end
    end
  end

  task automatic idle();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, MemWriteM} = '0;
    {BranchTakenE, MemAckM} = '0;
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_use();
    MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd5; RsD = 5'd5;
  endtask

  initial begin
    logic       raw_stall;
    logic [1:0] exp_m, exp_w;
    raw_stall = FWD ? 1'b0 : 1'b1;
    exp_m     = FWD ? 2'b10 : 2'b00;
    exp_w     = FWD ? 2'b01 : 2'b00;

    // Reset with hazards and a memory access present: outputs stay quiet.
    Rst_n = 1'b0;
    idle();
    load_use();
    MemReadM = 1; BranchTakenE = 1;
    @(negedge Clk);
    check("rst_req", 32'(MemReqM), 32'd0);
    check("rst_stallf", 32'(StallF), 32'd0);
    check("rst_flushd", 32'(FlushD), 32'd0);
    nxt(); idle(); Rst_n = 1'b1;
    @(negedge Clk);
    check("cnt_after_rst", 32'(StallCycles), 32'd0);

    // Load-use: one stall cycle.
    nxt(); load_use();
    @(negedge Clk);
    check("lu_stallf", 32'(StallF), 32'd1);
    check("lu_stalld", 32'(StallD), 32'd1);
    check("lu_flushe", 32'(FlushE), 32'd1);
    check("lu_stalle", 32'(StallE), 32'd0);
    nxt(); idle();
    @(negedge Clk);
    check("lu_gone", 32'(StallF), 32'd0);
    check("lu_count", 32'(StallCycles), 32'd1);

    // Register $0 is never a hazard.
    nxt(); MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd0; RsD = 5'd0;
    @(negedge Clk);
    check("zero_reg", 32'(StallF), 32'd0);

    // Plain RAW from EX and from MEM.
    nxt(); idle(); RegWriteE = 1; WriteRegE = 5'd7; RtD = 5'd7;
    @(negedge Clk);
    check("raw_e", 32'(StallF), 32'(raw_stall));
    nxt(); idle(); RegWriteM = 1; WriteRegM = 5'd9; RsD = 5'd9;
    @(negedge Clk);
    check("raw_m", 32'(StallF), 32'(raw_stall));

    // Forwarding priority and $0.
    nxt(); idle();
    RegWriteM = 1; WriteRegM = 5'd8; RegWriteW = 1; WriteRegW = 5'd8; RsE = 5'd8; RtE = 5'd8;
    @(negedge Clk);
    check("fwd_a_mem", 32'(ForwardAE), 32'(exp_m));
    check("fwd_b_mem", 32'(ForwardBE), 32'(exp_m));
    nxt(); RegWriteM = 0;
    @(negedge Clk);
    check("fwd_a_wb", 32'(ForwardAE), 32'(exp_w));
    nxt(); idle(); RegWriteM = 1; WriteRegM = 5'd0; RsE = 5'd0;
    @(negedge Clk);
    check("fwd_zero", 32'(ForwardAE), 32'd0);

    // Reset pulse clears the counter.
    nxt(); idle(); Rst_n = 1'b0;
    @(negedge Clk);
    check("pulse_cnt", 32'(StallCycles), 32'd0);
    nxt(); Rst_n = 1'b1;

    // Memory wait: three unacked cycles, release on the ack cycle.
    nxt(); MemReadM = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("mw_stallf", 32'(StallF), 32'd1);
      check("mw_stallm", 32'(StallM), 32'd1);
      check("mw_flushw", 32'(FlushW), 32'd1);
      check("mw_req", 32'(MemReqM), 32'd1);
      nxt();
    end
    MemAckM = 1;
    @(negedge Clk);
    check("mw_rel_stall", 32'(StallF), 32'd0);
    check("mw_rel_flushw", 32'(FlushW), 32'd0);
    check("mw_rel_req", 32'(MemReqM), 32'd1);
    nxt(); idle();
    @(negedge Clk);
    check("mw_count", 32'(StallCycles), 32'd3);

    // Branch beats load-use; branch during a wait is deferred.
    nxt(); load_use(); BranchTakenE = 1;
    @(negedge Clk);
    check("br_flushd", 32'(FlushD), 32'd1);
    check("br_flushe", 32'(FlushE), 32'd1);
    check("br_nostall", 32'(StallF), 32'd0);
    nxt(); idle(); MemReadM = 1; BranchTakenE = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("brw_flushd", 32'(FlushD), 32'd0);
      check("brw_stallf", 32'(StallF), 32'd1);
      nxt();
    end
    MemAckM = 1;
    @(negedge Clk);
    check("brw_rel_flushd", 32'(FlushD), 32'd1);
    check("brw_rel_flushe", 32'(FlushE), 32'd1);
    check("brw_rel_stallf", 32'(StallF), 32'd0);
    nxt(); idle();

    // Timeout into ERR, then reset recovers.
    MemWriteM = 1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge Clk);
      check("to_stallm", 32'(StallM), 32'd1);
      check("to_noerr", 32'(MemErr), 32'd0);
      nxt();
    end
    @(negedge Clk);
    check("to_err", 32'(MemErr), 32'd1);
    check("to_req", 32'(MemReqM), 32'd0);
    check("to_stallf", 32'(StallF), 32'd1);
    nxt(); idle();
    @(negedge Clk);
    check("err_sticky", 32'(MemErr), 32'd1);
    check("err_stallf", 32'(StallF), 32'd1);
    nxt(); Rst_n = 1'b0;
    @(negedge Clk);
    check("err_rst_err", 32'(MemErr), 32'd0);
    check("err_rst_cnt", 32'(StallCycles), 32'd0);
    nxt(); Rst_n = 1'b1; MemReadM = 1; MemAckM = 1;
    @(negedge Clk);
    check("post_req", 32'(MemReqM), 32'd1);
    check("post_stallf", 32'(StallF), 32'd0);
    check("post_err", 32'(MemErr), 32'd0);
    nxt(); idle();
    repeat (3) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
